// File: rtl/wb_store_queue.sv
// wb_store_queue: in-order store buffer between writeback and the dcache
// write port. Writeback enqueues validated stores, and the dcache drains them
// from the head. A combinational conflict check tells younger loads whether
// they overlap any pending or incoming store.
module wb_store_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic                       WB_V,
    input  logic [ADDR_W-1:0]          WB_Address,
    input  logic [DATA_W-1:0]          WB_Data,
    input  logic [1:0]                 WB_Datasize,
    output logic                       WB_stall,
    output logic                       Dcache_write_valid,
    output logic [ADDR_W-1:0]          Dcache_address,
    output logic [DATA_W-1:0]          Dcache_data,
    output logic [1:0]                 Dcache_datasize,
    input  logic                       In_write_ready,
    input  logic                       LD_V,
    input  logic [ADDR_W-1:0]          LD_Address,
    output logic                       SQ_hit,
    output logic [$clog2(DEPTH):0]     SQ_count,
    output logic                       SQ_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Conservative overlap test: quad stores compare at 8-byte granularity,
    // everything else at 4-byte granularity.
    function automatic logic addr_match(
        input logic [ADDR_W-1:0] st_addr,
        input logic [1:0]        st_size,
        input logic [ADDR_W-1:0] ld_addr
    );
        logic m;
        if (st_size == 2'd3) begin
            m = (st_addr[ADDR_W-1:3] == ld_addr[ADDR_W-1:3]);
        end else begin
            m = (st_addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);
        end
        return m;
    endfunction

    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic              valid_r [DEPTH];
    logic [ADDR_W-1:0] addr_r  [DEPTH];
    logic [DATA_W-1:0] data_r  [DEPTH];
    logic [1:0]        size_r  [DEPTH];

    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic              hit_s;
    logic [DEPTH-1:0]  entry_hit_s;

    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == {CNT_W{1'b0}});
    // A pop in the same cycle does not make room for a request that sees full.
    assign push_s  = WB_V & ~full_s;
    assign pop_s   = ~empty_s & In_write_ready;

    assign WB_stall           = WB_V & full_s;
    assign Dcache_write_valid = ~empty_s;
    assign Dcache_address     = addr_r[head_r];
    assign Dcache_data        = data_r[head_r];
    assign Dcache_datasize    = size_r[head_r];
    assign SQ_count           = count_r;
    assign SQ_empty           = empty_s;
    assign SQ_hit             = hit_s;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry_hit
        assign entry_hit_s[g] = valid_r[g] & addr_match(addr_r[g], size_r[g], LD_Address);
    end

    // Load conflict: any valid entry (including one popping now) or the incoming push.
    always_comb begin
        hit_s = 1'b0;
        if (LD_V) begin
            hit_s = (|entry_hit_s) |
                    (push_s & addr_match(WB_Address, WB_Datasize, LD_Address));
        end else begin
            hit_s = 1'b0;
        end
    end

    // Head/tail pointers and occupancy count.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage: fields written at tail on push, valid cleared at head on pop.
    // Push and pop never target the same slot in one cycle (that would need
    // the queue to be both empty and full).
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[PTR_W'(i)] <= 1'b0;
                addr_r[PTR_W'(i)]  <= {ADDR_W{1'b0}};
                data_r[PTR_W'(i)]  <= {DATA_W{1'b0}};
                size_r[PTR_W'(i)]  <= 2'd0;
            end
        end else begin
            if (pop_s) begin
                valid_r[head_r] <= 1'b0;
            end
            if (push_s) begin
                valid_r[tail_r] <= 1'b1;
                addr_r[tail_r]  <= WB_Address;
                data_r[tail_r]  <= WB_Data;
                size_r[tail_r]  <= WB_Datasize;
            end
        end
    end

endmodule

// File: tb/tb_wb_store_queue.sv
// Directed bench for wb_store_queue (DEPTH=4, ADDR_W=32, DATA_W=64).
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later.
module tb_wb_store_queue;

    logic        CLK;
    logic        CLR;
    logic        WB_V;
    logic [31:0] WB_Address;
    logic [63:0] WB_Data;
    logic [1:0]  WB_Datasize;
    logic        WB_stall;
    logic        Dcache_write_valid;
    logic [31:0] Dcache_address;
    logic [63:0] Dcache_data;
    logic [1:0]  Dcache_datasize;
    logic        In_write_ready;
    logic        LD_V;
    logic [31:0] LD_Address;
    logic        SQ_hit;
    logic [2:0]  SQ_count;
    logic        SQ_empty;

    int n_asrt = 0;
    int n_fail = 0;

    wb_store_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(64)) dut (
        .CLK(CLK), .CLR(CLR),
        .WB_V(WB_V), .WB_Address(WB_Address), .WB_Data(WB_Data),
        .WB_Datasize(WB_Datasize), .WB_stall(WB_stall),
        .Dcache_write_valid(Dcache_write_valid), .Dcache_address(Dcache_address),
        .Dcache_data(Dcache_data), .Dcache_datasize(Dcache_datasize),
        .In_write_ready(In_write_ready),
        .LD_V(LD_V), .LD_Address(LD_Address), .SQ_hit(SQ_hit),
        .SQ_count(SQ_count), .SQ_empty(SQ_empty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] a,
                            input logic [63:0] d, input logic [1:0] s);
        chk({tag, "_valid"}, {63'd0, Dcache_write_valid}, 64'd1);
        chk({tag, "_addr"},  {32'd0, Dcache_address}, {32'd0, a});
        chk({tag, "_data"},  Dcache_data, d);
        chk({tag, "_size"},  {62'd0, Dcache_datasize}, {62'd0, s});
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_empty"}, {63'd0, SQ_empty}, 64'd1);
        chk({tag, "_count"}, {61'd0, SQ_count}, 64'd0);
        chk({tag, "_dvalid"}, {63'd0, Dcache_write_valid}, 64'd0);
    endtask

    task automatic push_in(input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
        WB_V        = 1'b1;
        WB_Address  = a;
        WB_Data     = d;
        WB_Datasize = s;
    endtask

    initial begin
        CLR = 1'b0; WB_V = 1'b0; WB_Address = 32'd0; WB_Data = 64'd0;
        WB_Datasize = 2'd0; In_write_ready = 1'b0; LD_V = 1'b0; LD_Address = 32'd0;

        // ---- reset values ----
        #3;
        chk_empty("rst");
        chk("rst_addr", {32'd0, Dcache_address}, 64'd0);
        chk("rst_data", Dcache_data, 64'd0);
        chk("rst_size", {62'd0, Dcache_datasize}, 64'd0);
        WB_V = 1'b1;
        LD_V = 1'b1;
        settle();
        chk("rst_stall", {63'd0, WB_stall}, 64'd0);
        WB_V = 1'b0;
        settle();
        chk("rst_hit", {63'd0, SQ_hit}, 64'd0);
        LD_V = 1'b0;
        @(negedge CLK);
        CLR = 1'b1;
        tick();

        // ---- single store ----
        push_in(32'h0000_1000, 64'h0000_0000_DEAD_BEEF, 2'd2);
        In_write_ready = 1'b1;
        settle();
        chk("single_stall", {63'd0, WB_stall}, 64'd0);
        chk("single_nobypass", {63'd0, Dcache_write_valid}, 64'd0);
        tick();
        WB_V = 1'b0;
        settle();
        chk_head("single", 32'h0000_1000, 64'h0000_0000_DEAD_BEEF, 2'd2);
        chk("single_count", {61'd0, SQ_count}, 64'd1);
        tick();
        chk_empty("single_drained");

        // ---- fill and stall ----
        In_write_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            push_in(32'(k) << 8, 64'(k), 2'd0);
            settle();
            chk("fill_stall", {63'd0, WB_stall}, 64'd0);
            tick();
        end
        chk("fill_count", {61'd0, SQ_count}, 64'd4);
        push_in(32'h0000_0500, 64'd5, 2'd0);
        settle();
        chk("full_stall", {63'd0, WB_stall}, 64'd1);
        chk_head("full_head", 32'h0000_0100, 64'd1, 2'd0);
        In_write_ready = 1'b1;
        settle();
        chk("full_pop_stall", {63'd0, WB_stall}, 64'd1);
        tick();
        In_write_ready = 1'b0;
        settle();
        chk("after_pop_count", {61'd0, SQ_count}, 64'd3);
        chk("after_pop_stall", {63'd0, WB_stall}, 64'd0);
        tick();
        WB_V = 1'b0;
        chk("refill_count", {61'd0, SQ_count}, 64'd4);
        In_write_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            settle();
            chk_head("order", 32'(k) << 8, 64'(k), 2'd0);
            tick();
        end
        chk_empty("order_drained");

        // ---- simultaneous push/pop at count 2, pointers wrap ----
        In_write_ready = 1'b0;
        push_in(32'h0000_0600, 64'h10, 2'd1);
        tick();
        push_in(32'h0000_0604, 64'h11, 2'd1);
        tick();
        In_write_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_in(32'h0000_0608 + 32'(4 * i), 64'h12 + 64'(i), 2'd1);
            settle();
            chk("pp_count", {61'd0, SQ_count}, 64'd2);
            chk("pp_stall", {63'd0, WB_stall}, 64'd0);
            chk("pp_data", Dcache_data, 64'h10 + 64'(i));
            tick();
        end
        WB_V = 1'b0;
        settle();
        chk_head("pp_tail0", 32'h0000_0628, 64'h1A, 2'd1);
        tick();
        chk_head("pp_tail1", 32'h0000_062C, 64'h1B, 2'd1);
        tick();
        chk_empty("pp_drained");

        // ---- conflict query ----
        In_write_ready = 1'b0;
        push_in(32'h0000_2004, 64'hAAAA_BBBB, 2'd2);
        tick();
        push_in(32'h0000_3000, 64'h1234_5678_9ABC_DEF0, 2'd3);
        tick();
        WB_V = 1'b0;
        LD_V = 1'b1;
        LD_Address = 32'h0000_2006;
        settle();
        chk("hit_dword", {63'd0, SQ_hit}, 64'd1);
        LD_Address = 32'h0000_2008;
        settle();
        chk("miss_dword", {63'd0, SQ_hit}, 64'd0);
        LD_Address = 32'h0000_3004;
        settle();
        chk("hit_quad", {63'd0, SQ_hit}, 64'd1);
        LD_Address = 32'h0000_3008;
        settle();
        chk("miss_quad", {63'd0, SQ_hit}, 64'd0);

        // ---- backpressure stability with LD_V low ----
        LD_V = 1'b0;
        LD_Address = 32'h0000_2004;
        for (int i = 0; i < 7; i++) begin
            settle();
            chk_head("stable", 32'h0000_2004, 64'hAAAA_BBBB, 2'd2);
            chk("stable_hit_off", {63'd0, SQ_hit}, 64'd0);
            tick();
        end
        // entry popping this cycle still reported as a conflict
        In_write_ready = 1'b1;
        LD_V = 1'b1;
        settle();
        chk("hit_popping", {63'd0, SQ_hit}, 64'd1);
        tick();
        settle();
        chk_head("quad_head", 32'h0000_3000, 64'h1234_5678_9ABC_DEF0, 2'd3);
        tick();
        chk_empty("conf_drained");

        // incoming push on an empty queue hits
        LD_Address = 32'h0000_4000;
        push_in(32'h0000_4000, 64'h44, 2'd2);
        settle();
        chk("hit_incoming", {63'd0, SQ_hit}, 64'd1);
        In_write_ready = 1'b0;
        tick();

        // ---- reset mid-stream with 3 entries pending ----
        LD_V = 1'b0;
        push_in(32'h0000_4004, 64'h45, 2'd2);
        tick();
        push_in(32'h0000_4008, 64'h46, 2'd2);
        tick();
        WB_V = 1'b0;
        chk("pre_rst_count", {61'd0, SQ_count}, 64'd3);
        In_write_ready = 1'b1;
        #2;
        CLR = 1'b0;
        #1;
        chk_empty("mid_rst");
        chk("mid_rst_addr", {32'd0, Dcache_address}, 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        CLR = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_empty("post_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
